spectrum_accumulator: RTL and testbench

- Downstream consumer of the FFT core's serial output (20-bit real/imag bins, 256 per frame, startout-framed).
- Computes per-bin power re²+im², averages over 2^LOG2_AVG consecutive frames in a 256-entry accumulator memory, and streams the averaged spectrum in bin order with the same start-pulse framing.
- Output streams concurrently with the last frame of each averaging window; no extra frame buffer.

---
 rtl/fft_pkg.sv | 18 +
 rtl/power_calc.sv | 48 ++++
 rtl/spectrum_accumulator.sv | 199 +++++++++++++++++++
 tb/tb_spectrum_accumulator.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT post-processing blocks.
//   FFT_POINTS / BIN_W  - frame length and bin index width
//   SAMPLE_W            - default signed sample width of the FFT output
//   power_width()       - width of re^2 + im^2 for a given input width
//   state_t             - framing FSM states
package fft_pkg;

  localparam int FFT_POINTS = 256;
  localparam int BIN_W      = 8;
  localparam int SAMPLE_W   = 20;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int power_width(input int in_w);
    return 2 * in_w + 1;
  endfunction

endpackage

// File: rtl/power_calc.sv
// power_calc: two-stage registered power calculation, power = re^2 + im^2.
//   clk, reset          - clock, async active-high reset
//   valid_in, re, im    - input sample (signed, IN_W bits)
//   power, valid_out    - unsigned power (power_width(IN_W) bits), 2 cycles later
module power_calc
  import fft_pkg::*;
#(
  parameter int IN_W = SAMPLE_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic signed [IN_W-1:0]        re,
  input  logic signed [IN_W-1:0]        im,
  output logic [power_width(IN_W)-1:0]  power,
  output logic                          valid_out
);

  localparam int SQ_W = 2 * IN_W;

  logic signed [SQ_W-1:0] re_x, im_x, re_prod, im_prod;
  logic [SQ_W-1:0]        re_sq, im_sq;
  logic                   v_s1;

  // Operands widened first so the low SQ_W bits of the product are the exact
  // square; the square of a signed value always fits unsigned in SQ_W bits.
  assign re_x    = {{IN_W{re[IN_W-1]}}, re};
  assign im_x    = {{IN_W{im[IN_W-1]}}, im};
  assign re_prod = re_x * re_x;
  assign im_prod = im_x * im_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_s1      <= 1'b0;
      re_sq     <= '0;
      im_sq     <= '0;
      valid_out <= 1'b0;
      power     <= '0;
    end else begin
      v_s1      <= valid_in;
      re_sq     <= $unsigned(re_prod);
      im_sq     <= $unsigned(im_prod);
      valid_out <= v_s1;
      power     <= {1'b0, re_sq} + {1'b0, im_sq};
    end
  end

endmodule

// File: rtl/spectrum_accumulator.sv
// spectrum_accumulator: averages per-bin power over 2^LOG2_AVG FFT frames and
// streams the averaged spectrum during the last frame of each window.
//   clk, reset             - clock, async active-high reset
//   realin, imagin         - signed bin sample; startin marks bin 0
//   powout, outvalid       - averaged/shifted/saturated power, bins 0..255
//   startout               - pulse with output bin 0
//   frame_err              - pulse when startin arrives mid-frame
//   peak_bin, peak_valid   - max bin of last output frame (PEAK_DETECT_EN,
//                            otherwise tied to 0)
//
// state | meaning
// IDLE  | waiting for startin, samples ignored
// RUN   | receiving bins 1..255 of a frame
module spectrum_accumulator
  import fft_pkg::*;
#(
  parameter int IN_W      = SAMPLE_W,
  parameter int OUT_W     = 20,
  parameter int LOG2_AVG  = 2,
  parameter int OUT_SHIFT = 21
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] realin,
  input  logic signed [IN_W-1:0] imagin,
  input  logic                   startin,
  output logic [OUT_W-1:0]       powout,
  output logic                   outvalid,
  output logic                   startout,
  output logic                   frame_err,
  output logic [BIN_W-1:0]       peak_bin,
  output logic                   peak_valid
);

  localparam int PW    = power_width(IN_W);
  localparam int ACC_W = PW + LOG2_AVG;
  localparam int AVG   = 1 << LOG2_AVG;
  localparam int FC_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(AVG - 1);
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FFT_POINTS - 1);
  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'({OUT_W{1'b1}});

  state_t           state, state_n;
  logic [BIN_W-1:0] bin_cnt, bin_cnt_n, bin_in;
  logic [FC_W-1:0]  frame_cnt, frame_cnt_n;
  logic             accept, first_in, last_in, restart;

  always_comb begin
    state_n     = state;
    bin_cnt_n   = bin_cnt;
    frame_cnt_n = frame_cnt;
    accept      = 1'b0;
    restart     = 1'b0;
    bin_in      = '0;
    first_in    = (frame_cnt == '0);
    last_in     = (frame_cnt == FC_LAST);
    case (state)
      IDLE: begin
        if (startin) begin
          accept    = 1'b1;
          state_n   = RUN;
          bin_cnt_n = BIN_W'(1);
        end
      end
      RUN: begin
        accept = 1'b1;
        if (startin) begin
          // Mid-frame start: this sample opens a fresh window as bin 0.
          restart     = 1'b1;
          first_in    = 1'b1;
          last_in     = (AVG == 1);
          frame_cnt_n = '0;
          bin_cnt_n   = BIN_W'(1);
        end else begin
          bin_in    = bin_cnt;
          bin_cnt_n = bin_cnt + BIN_W'(1);
          if (bin_cnt == BIN_LAST) begin
            state_n     = IDLE;
            frame_cnt_n = last_in ? '0 : frame_cnt + FC_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign frame_err = restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      bin_cnt   <= bin_cnt_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  logic [PW-1:0]    power;
  logic             pc_valid;
  logic [BIN_W-1:0] bin_s1, bin_s2;
  logic             first_s1, last_s1, first_s2, last_s2;

  power_calc #(.IN_W(IN_W)) u_power_calc (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (accept),
    .re        (realin),
    .im        (imagin),
    .power     (power),
    .valid_out (pc_valid)
  );

  // Bin index and window flags travel alongside power_calc's two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_s1   <= '0;
      first_s1 <= 1'b0;
      last_s1  <= 1'b0;
      bin_s2   <= '0;
      first_s2 <= 1'b0;
      last_s2  <= 1'b0;
    end else begin
      bin_s1   <= bin_in;
      first_s1 <= first_in;
      last_s1  <= last_in;
      bin_s2   <= bin_s1;
      first_s2 <= first_s1;
      last_s2  <= last_s1;
    end
  end

  logic [ACC_W-1:0] acc_mem [FFT_POINTS];
  logic [ACC_W-1:0] acc_rd, sum, shifted;
  logic [OUT_W-1:0] pow_sat;

  // Same-bin accesses are a frame apart, so the read in S2 never needs the
  // write from S3. First frame of a window ignores stale contents.
  always_ff @(posedge clk) begin
    acc_rd <= acc_mem[bin_s1];
    if (pc_valid) acc_mem[bin_s2] <= sum;
  end

  assign sum     = first_s2 ? ACC_W'(power) : acc_rd + ACC_W'(power);
  assign shifted = sum >> (LOG2_AVG + OUT_SHIFT);
  assign pow_sat = (shifted > OUT_MAX) ? '1 : shifted[OUT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      powout   <= '0;
      outvalid <= 1'b0;
      startout <= 1'b0;
    end else begin
      powout   <= (pc_valid && last_s2) ? pow_sat : '0;
      outvalid <= pc_valid && last_s2;
      startout <= pc_valid && last_s2 && (bin_s2 == '0);
    end
  end

`ifdef PEAK_DETECT_EN
  logic [BIN_W-1:0] bin_out, run_idx, new_idx;
  logic [OUT_W-1:0] run_max, new_max;
  logic             take_new;

  // Strict greater-than keeps the lowest index on ties; startout reseeds.
  always_comb begin
    take_new = startout || (powout > run_max);
    new_max  = take_new ? powout  : run_max;
    new_idx  = take_new ? bin_out : run_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_out    <= '0;
      run_idx    <= '0;
      run_max    <= '0;
      peak_bin   <= '0;
      peak_valid <= 1'b0;
    end else begin
      bin_out    <= bin_s2;
      peak_valid <= 1'b0;
      if (outvalid) begin
        run_max <= new_max;
        run_idx <= new_idx;
        if (bin_out == BIN_LAST) begin
          peak_bin   <= new_idx;
          peak_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign peak_bin   = '0;
  assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spectrum_accumulator.sv
module tb_spectrum_accumulator;

  localparam int IN_W      = 20;
  localparam int OUT_W     = 20;
  localparam int LOG2_AVG  = 2;
  localparam int OUT_SHIFT = 0;
  localparam int NF        = 4;
  localparam longint MAXV  = (64'sd1 <<< OUT_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic signed [IN_W-1:0] realin = '0;
  logic signed [IN_W-1:0] imagin = '0;
  logic                   startin = 1'b0;
  logic [OUT_W-1:0]       powout;
  logic                   outvalid, startout, frame_err, peak_valid;
  logic [7:0]             peak_bin;

  always #5 clk = ~clk;

  spectrum_accumulator #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LOG2_AVG(LOG2_AVG), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .realin(realin), .imagin(imagin),
    .startin(startin), .powout(powout), .outvalid(outvalid),
    .startout(startout), .frame_err(frame_err), .peak_bin(peak_bin),
    .peak_valid(peak_valid)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation queues filled on the falling edge.
  int out_q[$], start_q[$], sin_q[$], err_q[$], peak_q[$], peak_cyc_q[$];
  int ov_first, ov_last, idle_bad = 0, peak_bad = 0;

  always @(negedge clk) begin
    if (startin) sin_q.push_back(cyc);
    if (frame_err) err_q.push_back(cyc);
    if (outvalid) begin
      if (out_q.size() == 0) ov_first = cyc;
      ov_last = cyc;
      out_q.push_back(int'(powout));
    end else if (powout !== '0) idle_bad++;
    if (startout) start_q.push_back(cyc);
    if (peak_valid) begin
      peak_q.push_back(int'(peak_bin));
      peak_cyc_q.push_back(cyc);
    end
`ifndef PEAK_DETECT_EN
    if (peak_bin !== 8'd0 || peak_valid !== 1'b0) peak_bad++;
`endif
  end

  // Reference model: frames of the current window and the averaged spectrum.
  int     w_re[NF][256];
  int     w_im[NF][256];
  longint exp_spec[256];

  task automatic compute_expected();
    for (int b = 0; b < 256; b++) begin
      longint s = 0;
      for (int f = 0; f < NF; f++)
        s += longint'(w_re[f][b]) * w_re[f][b] + longint'(w_im[f][b]) * w_im[f][b];
      s = (s / NF) >>> OUT_SHIFT;
      exp_spec[b] = (s > MAXV) ? MAXV : s;
    end
  endtask

  task automatic gen_random(input int f, input int amp);
    for (int b = 0; b < 256; b++) begin
      w_re[f][b] = int'($urandom_range(2 * amp)) - amp;
      w_im[f][b] = int'($urandom_range(2 * amp)) - amp;
    end
  endtask

  task automatic gen_const(input int f, input int re, input int im);
    for (int b = 0; b < 256; b++) begin
      w_re[f][b] = re;
      w_im[f][b] = im;
    end
  endtask

  task automatic drive_frame(input int f, input int nbins);
    for (int b = 0; b < nbins; b++) begin
      @(posedge clk); #1;
      startin = (b == 0);
      realin  = IN_W'(w_re[f][b]);
      imagin  = IN_W'(w_im[f][b]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      startin = 1'b0;
      realin  = IN_W'($urandom);
      imagin  = IN_W'($urandom);
    end
  endtask

  task automatic run_window(input bit gaps);
    for (int f = 0; f < NF; f++) begin
      drive_frame(f, 256);
      if (gaps) idle(int'($urandom_range(3)));
    end
    idle(8);
  endtask

  task automatic clear_mon();
    out_q.delete(); start_q.delete(); sin_q.delete(); err_q.delete();
    peak_q.delete(); peak_cyc_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (powout !== '0) begin fails++; $display("FAIL reset_powout got %0h exp 0", powout); end
    tests++; if (outvalid !== 1'b0) begin fails++; $display("FAIL reset_outvalid got %b exp 0", outvalid); end
    tests++; if (startout !== 1'b0) begin fails++; $display("FAIL reset_startout got %b exp 0", startout); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    tests++; if (peak_bin !== 8'd0) begin fails++; $display("FAIL reset_peak_bin got %0d exp 0", peak_bin); end
    tests++; if (peak_valid !== 1'b0) begin fails++; $display("FAIL reset_peak_valid got %b exp 0", peak_valid); end
    reset = 1'b0;
    clear_mon();
    idle(20);
    tests++; if (out_q.size() + start_q.size() + err_q.size() != 0) begin
      fails++; $display("FAIL idle_ignored got %0d events exp 0", out_q.size() + start_q.size() + err_q.size());
    end
  endtask

  task automatic test_constant();
    int bad = 0, first_bad = -1;
    clear_mon();
    for (int f = 0; f < NF; f++) gen_const(f, 3, 4);
    for (int f = 0; f < NF - 1; f++) drive_frame(f, 256);
    tests++; if (out_q.size() != 0) begin fails++; $display("FAIL const_early_out got %0d exp 0", out_q.size()); end
    drive_frame(NF - 1, 256);
    idle(8);
    tests++; if (start_q.size() != 1) begin fails++; $display("FAIL const_startout_cnt got %0d exp 1", start_q.size()); end
    else begin
      tests++; if (start_q[0] - sin_q[NF-1] != 3) begin
        fails++; $display("FAIL const_latency got %0d exp 3", start_q[0] - sin_q[NF-1]);
      end
    end
    tests++; if (out_q.size() != 256 || ov_last - ov_first != 255) begin
      fails++; $display("FAIL const_outvalid_len got %0d samples over %0d cycles exp 256", out_q.size(), ov_last - ov_first + 1);
    end
    foreach (out_q[i]) if (out_q[i] != 25) begin bad++; if (first_bad < 0) first_bad = i; end
    tests++; if (bad != 0) begin
      fails++; $display("FAIL const_powout %0d bins wrong, bin %0d got %0d exp 25", bad, first_bad, out_q[first_bad]);
    end
  endtask

  task automatic test_averaging();
    for (int it = 0; it < 2; it++) begin
      int bad = 0, first_bad = -1;
      clear_mon();
      for (int f = 0; f < NF; f++) begin
        gen_random(f, (it == 0) ? 700 : 1000);
        w_re[f][10] = 2 * f;
        w_im[f][10] = 0;
      end
      compute_expected();
      run_window(1'b1);
      tests++; if (out_q.size() != 256) begin
        fails++; $display("FAIL avg_count got %0d exp 256", out_q.size());
      end else begin
        foreach (out_q[i]) if (longint'(out_q[i]) != exp_spec[i]) begin bad++; if (first_bad < 0) first_bad = i; end
        tests++; if (bad != 0) begin
          fails++; $display("FAIL avg_spectrum %0d bins wrong, bin %0d got %0d exp %0d", bad, first_bad, out_q[first_bad], exp_spec[first_bad]);
        end
        tests++; if (out_q[10] != 14) begin fails++; $display("FAIL avg_bin10 got %0d exp 14", out_q[10]); end
      end
      tests++; if (start_q.size() != 1 || start_q[0] - sin_q[NF-1] != 3) begin
        fails++; $display("FAIL avg_startout got %0d pulses exp 1 at latency 3", start_q.size());
      end
    end
  endtask

  task automatic test_saturation();
    int bad = 0;
    clear_mon();
    for (int f = 0; f < NF; f++) gen_const(f, -524288, -524288);
    run_window(1'b0);
    foreach (out_q[i]) if (out_q[i] != 32'hFFFFF) bad++;
    tests++; if (out_q.size() != 256 || bad != 0) begin
      fails++; $display("FAIL saturation got %0d samples, %0d not FFFFF, exp 256 all FFFFF", out_q.size(), bad);
    end
  endtask

  task automatic test_restart();
    longint exp_a[256];
    int bad = 0, first_bad = -1;
    clear_mon();
    for (int f = 0; f < NF; f++) gen_random(f, 500);
    compute_expected();
    exp_a = exp_spec;
    for (int f = 0; f < NF - 1; f++) drive_frame(f, 256);
    drive_frame(NF - 1, 100);
    for (int f = 0; f < NF; f++) gen_random(f, 600);
    compute_expected();
    for (int f = 0; f < NF - 1; f++) drive_frame(f, 256);
    idle(8);
    tests++; if (err_q.size() != 1) begin fails++; $display("FAIL restart_err_cnt got %0d exp 1", err_q.size()); end
    else begin
      tests++; if (err_q[0] != sin_q[NF]) begin
        fails++; $display("FAIL restart_err_cycle got %0d exp %0d", err_q[0], sin_q[NF]);
      end
    end
    tests++; if (out_q.size() != 100) begin
      fails++; $display("FAIL restart_truncated got %0d samples exp 100", out_q.size());
    end else begin
      foreach (out_q[i]) if (longint'(out_q[i]) != exp_a[i]) begin bad++; if (first_bad < 0) first_bad = i; end
      tests++; if (bad != 0) begin
        fails++; $display("FAIL restart_partial %0d bins wrong, bin %0d got %0d exp %0d", bad, first_bad, out_q[first_bad], exp_a[first_bad]);
      end
    end
    clear_mon();
    drive_frame(NF - 1, 256);
    idle(8);
    bad = 0; first_bad = -1;
    tests++; if (out_q.size() != 256 || start_q.size() != 1) begin
      fails++; $display("FAIL restart_window got %0d samples %0d starts exp 256 and 1", out_q.size(), start_q.size());
    end else begin
      foreach (out_q[i]) if (longint'(out_q[i]) != exp_spec[i]) begin bad++; if (first_bad < 0) first_bad = i; end
      tests++; if (bad != 0) begin
        fails++; $display("FAIL restart_spectrum %0d bins wrong, bin %0d got %0d exp %0d", bad, first_bad, out_q[first_bad], exp_spec[first_bad]);
      end
    end
  endtask

  task automatic test_reset_mid_output();
    int bad = 0, first_bad = -1;
    for (int f = 0; f < NF; f++) gen_random(f, 400);
    for (int f = 0; f < NF - 1; f++) drive_frame(f, 256);
    clear_mon();
    fork
      drive_frame(NF - 1, 256);
      begin
        int budget = 400;
        while (out_q.size() < 50 && budget > 0) begin @(negedge clk); #1; budget--; end
        tests++; if (budget == 0) begin fails++; $display("FAIL rst_mid_wait got %0d samples exp 50", out_q.size()); end
        reset = 1'b1;
        #1;
        tests++; if (powout !== '0 || outvalid !== 1'b0 || startout !== 1'b0) begin
          fails++; $display("FAIL rst_mid_outputs got pow=%0h ov=%b so=%b exp all 0", powout, outvalid, startout);
        end
      end
    join
    idle(3);
    reset = 1'b0;
    idle(3);
    tests++; if (out_q.size() != 50) begin fails++; $display("FAIL rst_mid_stop got %0d samples exp 50", out_q.size()); end
    clear_mon();
    for (int f = 0; f < NF; f++) gen_random(f, 800);
    compute_expected();
    run_window(1'b1);
    tests++; if (out_q.size() != 256) begin
      fails++; $display("FAIL rst_new_count got %0d exp 256", out_q.size());
    end else begin
      foreach (out_q[i]) if (longint'(out_q[i]) != exp_spec[i]) begin bad++; if (first_bad < 0) first_bad = i; end
      tests++; if (bad != 0) begin
        fails++; $display("FAIL rst_new_spectrum %0d bins wrong, bin %0d got %0d exp %0d", bad, first_bad, out_q[first_bad], exp_spec[first_bad]);
      end
    end
  endtask

  task automatic test_peak();
    int peaks[3] = '{37, 5, 0};
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      for (int f = 0; f < NF; f++) begin
        gen_const(f, 0, 0);
        if (t == 0) w_re[f][37] = 1000;
        if (t == 1) begin w_re[f][5] = 1000; w_im[f][9] = -1000; end
      end
      run_window(1'b0);
`ifdef PEAK_DETECT_EN
      tests++; if (peak_q.size() != 1) begin
        fails++; $display("FAIL peak_valid_cnt case %0d got %0d exp 1", t, peak_q.size());
      end else begin
        tests++; if (peak_q[0] != peaks[t]) begin
          fails++; $display("FAIL peak_bin case %0d got %0d exp %0d", t, peak_q[0], peaks[t]);
        end
        tests++; if (peak_cyc_q[0] != ov_last + 1) begin
          fails++; $display("FAIL peak_timing case %0d got %0d exp %0d", t, peak_cyc_q[0], ov_last + 1);
        end
      end
`else
      tests++; if (peak_q.size() != 0 || peak_bad != 0) begin
        fails++; $display("FAIL peak_tied_off case %0d got %0d pulses %0d nonzero exp 0 (peak %0d)", t, peak_q.size(), peak_bad, peaks[t]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_averaging();
    test_saturation();
    test_restart();
    test_reset_mid_output();
    test_peak();
    tests++; if (idle_bad != 0) begin fails++; $display("FAIL powout_idle got %0d nonzero cycles exp 0", idle_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
